uart_frame_tx: RTL and testbench

//  Packetiser feeding uart_tx. Takes one N_BYTES decoder result word and sends it as a framed byte stream:

---
 rtl/uart_frame_tx.sv | 151 +++++++++++++++
 tb/tb_uart_frame_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx
//   Packetiser in front of uart_tx. Accepts one N_BYTES payload word and
//   sends it as a framed byte stream: HEADER, payload bytes LSB-first,
//   then an 8-bit checksum (sum of the payload bytes mod 256). Each byte is
//   handed to uart_tx with a one-cycle start pulse and is held on tx_data
//   until uart_tx reports idle again.
//
// Parameters
//   N_BYTES    payload bytes per frame (1..16)
//   HEADER     first byte of every frame
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   payload word valid
//   in_data     in   payload, byte k = in_data[8k+7:8k], byte 0 sent first
//   in_ready    out  word can be accepted (idle)
//   tx_ready    in   uart_tx idle
//   tx_start    out  one-cycle start pulse per byte (registered)
//   tx_data     out  byte being sent (registered, stable while in flight)
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse once the checksum byte has been sent
module uart_frame_tx #(
    parameter int unsigned N_BYTES = 4,
    parameter logic [7:0]  HEADER  = 8'hAA
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [8*N_BYTES-1:0] in_data,
    output logic                 in_ready,
    input  logic                 tx_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned      IDX_W    = $clog2(N_BYTES + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [8*N_BYTES-1:0] payload_q, payload_d;
    logic [7:0]           csum_q, csum_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 frame_done_q, frame_done_d;
    logic [7:0]           in_sum;
    logic [7:0]           next_byte;

    // Checksum of the incoming word, carries discarded.
    always_comb begin
        in_sum = '0;
        for (int unsigned k = 0; k < N_BYTES; k++) begin
            in_sum = in_sum + in_data[8*k +: 8];
        end
    end

    // Byte that follows position idx_q: payload byte idx_q while idx_q is
    // below N_BYTES, otherwise the checksum.
    always_comb begin
        next_byte = csum_q;
        for (int unsigned k = 0; k < N_BYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                next_byte = payload_q[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        payload_d    = payload_q;
        csum_d       = csum_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    payload_d = in_data;
                    csum_d    = in_sum;
                    idx_d     = '0;
                    tx_data_d = HEADER;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    tx_start_d = 1'b1;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // uart_tx drops ready one cycle after sampling start.
                if (!tx_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        tx_data_d = next_byte;
                        state_d   = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            payload_q    <= '0;
            csum_q       <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            payload_q    <= payload_d;
            csum_q       <= csum_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench for uart_frame_tx with a behavioural uart_tx (BPS=4, 10-bit
// frames) and a frame-level reference model of the expected byte stream.
module tb_uart_frame_tx;

    localparam int unsigned NB       = 4;
    localparam int unsigned FLEN     = NB + 2;
    localparam logic [7:0]  HDR      = 8'hAA;
    localparam int unsigned UART_CYC = 10 * 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic [8*NB-1:0] in_data = '0;
    logic          stall    = 1'b0;
    logic          in_ready, tx_ready, tx_start, busy, frame_done;
    logic [7:0]    tx_data;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned fd_count = 0;
    logic [7:0]  log_q[$];

    uart_frame_tx #(.N_BYTES(NB), .HEADER(HDR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx_ready   (tx_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // uart_tx stand-in: samples start while idle, drops ready on that edge,
    // stays busy for one 10-bit frame of 4 cycles per bit.
    logic        u_ready;
    int unsigned u_cnt;
    logic [7:0]  u_byte;
    assign tx_ready = u_ready && !stall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_ready <= 1'b1;
            u_cnt   <= 0;
            u_byte  <= '0;
        end else if (u_cnt != 0) begin
            u_cnt <= u_cnt - 1;
            if (u_cnt == 1) u_ready <= 1'b1;
        end else if (tx_start) begin
            u_ready <= 1'b0;
            u_cnt   <= UART_CYC;
            u_byte  <= tx_data;
        end
    end

    // Reference model: a word is taken whenever no frame is outstanding; its
    // frame bytes are queued; the frame ends on the first edge the UART is
    // idle again after the last byte's start was taken.
    logic        m_busy, m_seen_low, exp_fd;
    int unsigned m_starts;
    logic [7:0]  exp_q[$];

    always @(posedge clk or negedge rst_n) begin : mdl
        int unsigned s;
        logic [7:0]  b;
        if (!rst_n) begin
            m_busy     <= 1'b0;
            m_seen_low <= 1'b0;
            exp_fd     <= 1'b0;
            m_starts   <= 0;
            exp_q.delete();
        end else begin
            exp_fd <= 1'b0;
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy     <= 1'b1;
                    m_starts   <= 0;
                    m_seen_low <= 1'b0;
                    exp_q.push_back(HDR);
                    s = 0;
                    for (int unsigned k = 0; k < NB; k++) begin
                        b = in_data[8*k +: 8];
                        exp_q.push_back(b);
                        s = s + b;
                    end
                    exp_q.push_back(8'(s % 256));
                end
            end else begin
                if (m_starts == FLEN) begin
                    if (!tx_ready) m_seen_low <= 1'b1;
                    else if (m_seen_low) begin
                        m_busy <= 1'b0;
                        exp_fd <= 1'b1;
                    end
                end
                if (tx_start) m_starts <= m_starts + 1;
            end
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    logic prev_start;
    always @(negedge clk) begin : cmp
        logic [7:0] e;
        if (rst_n) begin
            chk(in_ready === !m_busy, "in_ready", 32'(in_ready), 32'(!m_busy));
            chk(busy === m_busy, "busy", 32'(busy), 32'(m_busy));
            chk(frame_done === exp_fd, "frame_done", 32'(frame_done), 32'(exp_fd));
            if (frame_done === 1'b1) fd_count++;
            if (prev_start) chk(tx_start === 1'b0, "start_pulse_width", 32'(tx_start), 32'h0);
            if (tx_start === 1'b1) begin
                log_q.push_back(tx_data);
                chk(u_cnt == 0, "start_while_uart_busy", u_cnt, 32'h0);
                if (exp_q.size() == 0) chk(1'b0, "unexpected_start", 32'(tx_data), 32'h0);
                else begin
                    e = exp_q.pop_front();
                    chk(tx_data === e, "tx_byte", 32'(tx_data), 32'(e));
                end
            end else if (!u_ready) begin
                chk(tx_data === u_byte, "tx_data_stable", 32'(tx_data), 32'(u_byte));
            end
            prev_start <= tx_start;
        end else begin
            prev_start <= 1'b0;
        end
    end

    task automatic send_word(input logic [31:0] w);
        bit done;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = w;
        done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk);
            if (!m_busy) done = 1'b1;
        end
        if (!done) chk(1'b0, "accept_timeout", 32'(m_busy), 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge clk);
            if (!m_busy && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) chk(1'b0, "idle_timeout", 32'(exp_q.size()), 32'h0);
        @(negedge clk);
    endtask

    task automatic wait_log(input int unsigned n);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk);
            if (log_q.size() >= n) done = 1'b1;
        end
        if (!done) chk(1'b0, "log_timeout", 32'(log_q.size()), n);
    endtask

    // e holds six bytes, first-on-line byte in the top octet.
    task automatic check_frame(input string nm, input int unsigned base, input logic [47:0] e);
        logic [7:0] want;
        for (int unsigned i = 0; i < 6; i++) begin
            want = e[8*(5-i) +: 8];
            if (base + i < log_q.size())
                chk(log_q[base+i] === want, nm, 32'(log_q[base+i]), 32'(want));
            else
                chk(1'b0, nm, 32'hFFFF_FFFF, 32'(want));
        end
    endtask

    initial begin
        int unsigned fd0;
        logic [7:0]  hold;

        // Reset state
        repeat (3) @(negedge clk);
        chk(in_ready === 1'b1, "rst_in_ready", 32'(in_ready), 32'h1);
        chk(busy === 1'b0, "rst_busy", 32'(busy), 32'h0);
        chk(tx_start === 1'b0, "rst_tx_start", 32'(tx_start), 32'h0);
        chk(tx_data === 8'h00, "rst_tx_data", 32'(tx_data), 32'h0);
        chk(frame_done === 1'b0, "rst_frame_done", 32'(frame_done), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic frame
        log_q.delete(); fd0 = fd_count;
        send_word(32'h04030201);
        wait_idle();
        chk(log_q.size() == 6, "f1_len", 32'(log_q.size()), 32'd6);
        check_frame("f1_byte", 0, 48'hAA_01_02_03_04_0A);
        chk(fd_count - fd0 == 1, "f1_done_count", fd_count - fd0, 32'd1);

        // Checksum truncation
        log_q.delete();
        send_word(32'hFFFFFFFF);
        wait_idle();
        check_frame("f2_byte", 0, 48'hAA_FF_FF_FF_FF_FC);

        // Back-to-back frames, second word held until taken
        log_q.delete(); fd0 = fd_count;
        send_word(32'h04030201);
        send_word(32'h80706050);
        wait_idle();
        chk(log_q.size() == 12, "b2b_len", 32'(log_q.size()), 32'd12);
        check_frame("b2b_first", 0, 48'hAA_01_02_03_04_0A);
        check_frame("b2b_second", 6, 48'hAA_50_60_70_80_A0);
        chk(fd_count - fd0 == 2, "b2b_done_count", fd_count - fd0, 32'd2);

        // in_valid pulse while busy is ignored
        log_q.delete(); fd0 = fd_count;
        send_word(32'h11223344);
        repeat (30) @(posedge clk);
        #1 in_valid = 1'b1; in_data = 32'hDEADBEEF;
        @(negedge clk);
        chk(in_ready === 1'b0, "busy_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1 in_valid = 1'b0;
        wait_idle();
        chk(log_q.size() == 6, "busy_len", 32'(log_q.size()), 32'd6);
        check_frame("busy_byte", 0, 48'hAA_44_33_22_11_AA);
        chk(fd_count - fd0 == 1, "busy_done_count", fd_count - fd0, 32'd1);

        // tx_ready held low for 100 cycles while a byte is in flight
        log_q.delete();
        send_word(32'hCAFEF00D);
        wait_log(2);
        @(posedge clk); #1 stall = 1'b1;
        hold = tx_data;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk(tx_start === 1'b0, "stall_no_start", 32'(tx_start), 32'h0);
            chk(tx_data === hold, "stall_data_hold", 32'(tx_data), 32'(hold));
        end
        chk(busy === 1'b1, "stall_busy", 32'(busy), 32'h1);
        @(posedge clk); #1 stall = 1'b0;
        wait_idle();
        check_frame("stall_byte", 0, 48'hAA_0D_F0_FE_CA_C5);

        // Reset asserted right as a payload start pulse is out
        log_q.delete();
        send_word(32'h55667788);
        wait_log(3);
        #1 rst_n = 1'b0;
        #1;
        chk(tx_start === 1'b0, "mrst_tx_start", 32'(tx_start), 32'h0);
        chk(busy === 1'b0, "mrst_busy", 32'(busy), 32'h0);
        chk(in_ready === 1'b1, "mrst_in_ready", 32'(in_ready), 32'h1);
        chk(tx_data === 8'h00, "mrst_tx_data", 32'(tx_data), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        log_q.delete();
        send_word(32'h0A0B0C0D);
        wait_idle();
        check_frame("post_rst_byte", 0, 48'hAA_0D_0C_0B_0A_2E);

        // Randomized words with random idle gaps
        fd0 = fd_count;
        for (int n = 0; n < 10; n++) begin
            repeat ($urandom_range(0, 30)) @(posedge clk);
            send_word($urandom);
        end
        wait_idle();
        chk(fd_count - fd0 == 10, "rand_done_count", fd_count - fd0, 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog");
    end

endmodule
